// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register bank: access-mode encodings and the
// byte-strobe to bit-mask expansion used by the write path.
package reg_bank_pkg;

   typedef enum logic [1:0] {
      MODE_RW  = 2'd0,
      MODE_RO  = 2'd1,
      MODE_W1C = 2'd2,
      MODE_WO  = 2'd3
   } mode_e;

   // Widest register the mask helper can serve; callers size-cast in and out.
   localparam int MAX_DATA_W = 1024;
   localparam int MAX_STRB_W = MAX_DATA_W / 8;

   function automatic logic [MAX_DATA_W-1:0] strb_to_mask(input logic [MAX_STRB_W-1:0] strb);
      logic [MAX_DATA_W-1:0] mask;
      mask = '0;
      for (int b = 0; b < MAX_STRB_W; b++) begin
         mask[8*b +: 8] = {8{strb[b]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Bus-side request/response bundle between the request decoder (master)
// and the register bank (slave).
interface reg_bank_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  write;
   logic [ADDR_W-1:0]     write_addr;
   logic [DATA_W-1:0]     write_data;
   logic [DATA_W/8-1:0]   write_strb;
   logic                  read;
   logic [ADDR_W-1:0]     read_addr;
   logic                  write_ack;
   logic                  write_err;
   logic                  read_valid;
   logic                  read_err;
   logic [DATA_W-1:0]     read_data;

   modport master (
      output write, write_addr, write_data, write_strb, read, read_addr,
      input  write_ack, write_err, read_valid, read_err, read_data
   );

   modport slave (
      input  write, write_addr, write_data, write_strb, read, read_addr,
      output write_ack, write_err, read_valid, read_err, read_data
   );
endinterface

// File: rtl/reg_bank_cell.sv
// One register of the bank; MODE selects read-write, read-only status,
// write-1-to-clear event or write-only behaviour.
module reg_bank_cell
   import reg_bank_pkg::*;
#(
   parameter int    DATA_W = 32,
   parameter mode_e MODE   = MODE_RW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hit,
   input  logic [DATA_W-1:0] data,
   input  logic [DATA_W-1:0] mask,
   input  logic [DATA_W-1:0] hw_set,
   input  logic [DATA_W-1:0] hw_status,
   output logic [DATA_W-1:0] stored,
   output logic [DATA_W-1:0] rd_value
);

   generate
      if (MODE == MODE_RO) begin : g_ro
         // Status is live from hardware; there is nothing to store.
         assign stored   = '0;
         assign rd_value = hw_status;
         logic unused_ro;
         assign unused_ro = ^{clk, rst, hit, data, mask, hw_set};
      end else begin : g_store
         logic [DATA_W-1:0] value;
         logic [DATA_W-1:0] value_next;

         // NOTE: default assigned first so no path through the block infers a latch.
         always_comb begin
            value_next = value;
            if (MODE == MODE_W1C) begin
               // OR-ing hw_set after the clear makes a same-cycle set win.
               value_next = (value & ~(hit ? (data & mask) : '0)) | hw_set;
            end else if (hit) begin
               value_next = (value & ~mask) | (data & mask);
            end
         end

         // NOTE: non-blocking so every register samples pre-edge values.
         always_ff @(posedge clk) begin
            if (rst) value <= '0;
            else     value <= value_next;
         end

         assign stored   = value;
         assign rd_value = (MODE == MODE_WO) ? '0 : value;
         logic unused_store;
         assign unused_store = ^{hw_status, hw_set};
      end
   endgenerate

endmodule

// File: rtl/reg_bank.sv
// Memory-mapped register bank: address decode, per-register cells, read mux
// and registered single-cycle write/read responses.
module reg_bank
   import reg_bank_pkg::*;
#(
   parameter int                  DATA_W   = 32,
   parameter int                  ADDR_W   = 32,
   parameter int                  NUM_REGS = 8,
   parameter int                  STRIDE   = 4,
   parameter logic [2*NUM_REGS-1:0] MODES  = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   reg_bank_if.slave                  bus,
   input  logic [NUM_REGS*DATA_W-1:0] hw_status,
   input  logic [NUM_REGS*DATA_W-1:0] hw_set,
   output logic [NUM_REGS*DATA_W-1:0] regs_out
);

   localparam int                SHIFT       = $clog2(STRIDE);
   localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(STRIDE - 1);

   logic [ADDR_W-1:0]   w_index;
   logic [ADDR_W-1:0]   r_index;
   logic                w_mapped;
   logic                r_mapped;
   logic [NUM_REGS-1:0] w_hit;
   logic [DATA_W-1:0]   w_mask;
   logic [DATA_W-1:0]   rd_values [NUM_REGS];
   logic [DATA_W-1:0]   rd_mux;

   assign w_index  = bus.write_addr >> SHIFT;
   assign r_index  = bus.read_addr >> SHIFT;
   assign w_mapped = ((bus.write_addr & OFFSET_MASK) == '0) && (w_index < ADDR_W'(NUM_REGS));
   assign r_mapped = ((bus.read_addr & OFFSET_MASK) == '0) && (r_index < ADDR_W'(NUM_REGS));
   assign w_mask   = DATA_W'(strb_to_mask(MAX_STRB_W'(bus.write_strb)));

   generate
      for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
         assign w_hit[i] = bus.write && w_mapped && (w_index == ADDR_W'(i));

         reg_bank_cell #(
            .DATA_W (DATA_W),
            .MODE   (mode_e'(MODES[2*i +: 2]))
         ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .hit       (w_hit[i]),
            .data      (bus.write_data),
            .mask      (w_mask),
            .hw_set    (hw_set[i*DATA_W +: DATA_W]),
            .hw_status (hw_status[i*DATA_W +: DATA_W]),
            .stored    (regs_out[i*DATA_W +: DATA_W]),
            .rd_value  (rd_values[i])
         );
      end
   endgenerate

   // Cells show pre-edge contents here, so a same-cycle write is not visible.
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (r_index == ADDR_W'(i)) rd_mux = rd_values[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.write_ack  <= 1'b0;
         bus.write_err  <= 1'b0;
         bus.read_valid <= 1'b0;
         bus.read_err   <= 1'b0;
         bus.read_data  <= '0;
      end else begin
         bus.write_ack  <= bus.write && w_mapped;
         bus.write_err  <= bus.write && !w_mapped;
         bus.read_valid <= bus.read && r_mapped;
         bus.read_err   <= bus.read && !r_mapped;
         bus.read_data  <= (bus.read && r_mapped) ? rd_mux : '0;
      end
   end

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: regs 0,1,5-7 RW, reg 2 W1C, reg 3 RO, reg 4 WO.
module tb_reg_bank;
   import reg_bank_pkg::*;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 32;
   localparam int NUM_REGS = 8;
   localparam logic [15:0] MODES = 16'h0360;

   logic clk = 1'b0;
   logic rst;
   logic [NUM_REGS*DATA_W-1:0] hw_status;
   logic [NUM_REGS*DATA_W-1:0] hw_set;
   logic [NUM_REGS*DATA_W-1:0] regs_out;

   reg_bank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   reg_bank #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_REGS (NUM_REGS),
      .STRIDE   (4),
      .MODES    (MODES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .hw_status (hw_status),
      .hw_set    (hw_set),
      .regs_out  (regs_out)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   logic [DATA_W-1:0] exp_regs [NUM_REGS];

   function automatic logic [NUM_REGS*DATA_W-1:0] exp_vec();
      logic [NUM_REGS*DATA_W-1:0] v;
      for (int i = 0; i < NUM_REGS; i++) v[i*DATA_W +: DATA_W] = exp_regs[i];
      return v;
   endfunction

   task automatic idle();
      bus.write = 1'b0; bus.write_addr = '0; bus.write_data = '0; bus.write_strb = '0;
      bus.read = 1'b0;  bus.read_addr = '0;
      hw_set = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      bus.write = 1'b1; bus.write_addr = addr; bus.write_data = data; bus.write_strb = strb;
   endtask

   task automatic set_rd(input logic [31:0] addr);
      bus.read = 1'b1; bus.read_addr = addr;
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      set_wr(32'h0, 32'hFFFF_FFFF, 4'hF);
      set_rd(32'h0);
      tick();
      idle();
      rst = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
      n_total++;
      if ({bus.write_ack, bus.write_err, bus.read_valid, bus.read_err} !== 4'b0000)
         $display("FAIL reset_flags: got %b expected 0000", {bus.write_ack, bus.write_err, bus.read_valid, bus.read_err});
      else n_pass++;
      n_total++;
      if (bus.read_data !== 32'h0) $display("FAIL reset_read_data: got %h expected 0", bus.read_data);
      else n_pass++;
      n_total++;
      if (regs_out !== exp_vec()) $display("FAIL reset_regs: got %h expected %h", regs_out, exp_vec());
      else n_pass++;
   endtask

   task automatic test_rw_basic();
      set_wr(32'h0, 32'hDEAD_BEEF, 4'hF);
      tick();
      idle();
      exp_regs[0] = 32'hDEAD_BEEF;
      n_total++;
      if ({bus.write_ack, bus.write_err} !== 2'b10) $display("FAIL rw_write_ack: got %b expected 10", {bus.write_ack, bus.write_err});
      else n_pass++;
      n_total++;
      if (regs_out[31:0] !== 32'hDEAD_BEEF) $display("FAIL rw_regs_out0: got %h expected deadbeef", regs_out[31:0]);
      else n_pass++;
      set_rd(32'h0);
      tick();
      idle();
      n_total++;
      if (bus.write_ack !== 1'b0) $display("FAIL rw_ack_single_pulse: got %b expected 0", bus.write_ack);
      else n_pass++;
      n_total++;
      if ({bus.read_valid, bus.read_err, bus.read_data} !== {2'b10, 32'hDEAD_BEEF})
         $display("FAIL rw_read0: got v=%b e=%b d=%h expected v=1 e=0 d=deadbeef", bus.read_valid, bus.read_err, bus.read_data);
      else n_pass++;
   endtask

   task automatic test_strobe();
      set_wr(32'h4, 32'h1122_3344, 4'hF);
      tick();
      set_wr(32'h4, 32'hAABB_CCDD, 4'b0101);
      tick();
      idle();
      exp_regs[1] = 32'h11BB_33DD;
      n_total++;
      if (regs_out[63:32] !== 32'h11BB_33DD) $display("FAIL strobe_partial: got %h expected 11bb33dd", regs_out[63:32]);
      else n_pass++;
      set_wr(32'h4, 32'hFFFF_FFFF, 4'h0);
      tick();
      idle();
      n_total++;
      if ({bus.write_ack, regs_out[63:32]} !== {1'b1, 32'h11BB_33DD})
         $display("FAIL strobe_zero: got ack=%b reg=%h expected ack=1 reg=11bb33dd", bus.write_ack, regs_out[63:32]);
      else n_pass++;
   endtask

   task automatic test_w1c();
      hw_set[95:64] = 32'hF0;
      tick();
      idle();
      n_total++;
      if (regs_out[95:64] !== 32'hF0) $display("FAIL w1c_set: got %h expected f0", regs_out[95:64]);
      else n_pass++;
      set_wr(32'h8, 32'h30, 4'hF);
      hw_set[95:64] = 32'h10;
      tick();
      idle();
      exp_regs[2] = 32'hD0;
      n_total++;
      if (regs_out[95:64] !== 32'hD0) $display("FAIL w1c_clear_set_wins: got %h expected d0", regs_out[95:64]);
      else n_pass++;
      set_wr(32'h8, 32'hFF, 4'h0);
      set_rd(32'h8);
      tick();
      idle();
      n_total++;
      if ({bus.write_ack, regs_out[95:64], bus.read_data} !== {1'b1, 32'hD0, 32'hD0})
         $display("FAIL w1c_zero_strb: got ack=%b reg=%h rd=%h expected ack=1 reg=d0 rd=d0", bus.write_ack, regs_out[95:64], bus.read_data);
      else n_pass++;
   endtask

   task automatic test_errors();
      logic [31:0] bad_rd [2];
      bad_rd[0] = 32'h6;
      bad_rd[1] = 32'h20;
      for (int k = 0; k < 2; k++) begin
         set_rd(bad_rd[k]);
         tick();
         idle();
         n_total++;
         if ({bus.read_valid, bus.read_err, bus.read_data} !== {2'b01, 32'h0})
            $display("FAIL read_err_%h: got v=%b e=%b d=%h expected v=0 e=1 d=0", bad_rd[k], bus.read_valid, bus.read_err, bus.read_data);
         else n_pass++;
      end
      set_wr(32'h20, 32'h5555_5555, 4'hF);
      tick();
      idle();
      n_total++;
      if ({bus.write_ack, bus.write_err} !== 2'b01) $display("FAIL write_err_oor: got %b expected 01", {bus.write_ack, bus.write_err});
      else n_pass++;
      set_wr(32'h5, 32'h5555_5555, 4'hF);
      tick();
      idle();
      n_total++;
      if ({bus.write_ack, bus.write_err} !== 2'b01) $display("FAIL write_err_misaligned: got %b expected 01", {bus.write_ack, bus.write_err});
      else n_pass++;
      n_total++;
      if (regs_out !== exp_vec()) $display("FAIL write_err_no_change: got %h expected %h", regs_out, exp_vec());
      else n_pass++;
   endtask

   task automatic test_simultaneous();
      set_wr(32'h0, 32'h9, 4'hF);
      tick();
      set_wr(32'h0, 32'h5, 4'hF);
      set_rd(32'h0);
      tick();
      idle();
      exp_regs[0] = 32'h5;
      n_total++;
      if ({bus.write_ack, bus.read_valid, bus.read_data} !== {2'b11, 32'h9})
         $display("FAIL sim_old_value: got ack=%b v=%b d=%h expected ack=1 v=1 d=9", bus.write_ack, bus.read_valid, bus.read_data);
      else n_pass++;
      set_rd(32'h0);
      tick();
      idle();
      n_total++;
      if (bus.read_data !== 32'h5) $display("FAIL sim_new_value: got %h expected 5", bus.read_data);
      else n_pass++;
   endtask

   task automatic test_ro();
      set_wr(32'hC, 32'h1, 4'hF);
      tick();
      idle();
      n_total++;
      if ({bus.write_ack, bus.write_err, regs_out[127:96]} !== {2'b10, 32'h0})
         $display("FAIL ro_write: got ack=%b err=%b reg=%h expected ack=1 err=0 reg=0", bus.write_ack, bus.write_err, regs_out[127:96]);
      else n_pass++;
      set_rd(32'hC);
      tick();
      idle();
      n_total++;
      if ({bus.read_valid, bus.read_data} !== {1'b1, 32'hCAFE})
         $display("FAIL ro_read: got v=%b d=%h expected v=1 d=cafe", bus.read_valid, bus.read_data);
      else n_pass++;
   endtask

   task automatic test_wo();
      set_wr(32'h10, 32'h1234_5678, 4'hF);
      tick();
      idle();
      exp_regs[4] = 32'h1234_5678;
      n_total++;
      if (regs_out[159:128] !== 32'h1234_5678) $display("FAIL wo_regs_out: got %h expected 12345678", regs_out[159:128]);
      else n_pass++;
      set_rd(32'h10);
      tick();
      idle();
      n_total++;
      if ({bus.read_valid, bus.read_err, bus.read_data} !== {2'b10, 32'h0})
         $display("FAIL wo_read: got v=%b e=%b d=%h expected v=1 e=0 d=0", bus.read_valid, bus.read_err, bus.read_data);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [3];
      vals[0] = 32'hA5A5_A5A5;
      vals[1] = 32'h5A5A_5A5A;
      vals[2] = 32'h0102_0304;
      for (int k = 0; k < 3; k++) begin
         set_wr(32'h14 + 32'(4*k), vals[k], 4'hF);
         tick();
         exp_regs[5+k] = vals[k];
         n_total++;
         if ({bus.write_ack, bus.write_err} !== 2'b10) $display("FAIL b2b_write%0d: got %b expected 10", k, {bus.write_ack, bus.write_err});
         else n_pass++;
      end
      idle();
      for (int k = 0; k < 3; k++) begin
         set_rd(32'h14 + 32'(4*k));
         tick();
         n_total++;
         if ({bus.read_valid, bus.read_data} !== {1'b1, vals[k]})
            $display("FAIL b2b_read%0d: got v=%b d=%h expected v=1 d=%h", k, bus.read_valid, bus.read_data, vals[k]);
         else n_pass++;
      end
      idle();
      n_total++;
      if (regs_out !== exp_vec()) $display("FAIL b2b_all_regs: got %h expected %h", regs_out, exp_vec());
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      set_wr(32'h0, 32'h77, 4'hF);
      set_rd(32'h4);
      tick();
      rst = 1'b1;
      set_wr(32'h4, 32'h88, 4'hF);
      set_rd(32'h0);
      tick();
      rst = 1'b0;
      idle();
      for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = '0;
      n_total++;
      if ({bus.write_ack, bus.write_err, bus.read_valid, bus.read_err, bus.read_data} !== {4'b0000, 32'h0})
         $display("FAIL reset_mid_outputs: got ack=%b werr=%b v=%b rerr=%b d=%h expected all 0",
                  bus.write_ack, bus.write_err, bus.read_valid, bus.read_err, bus.read_data);
      else n_pass++;
      n_total++;
      if (regs_out !== exp_vec()) $display("FAIL reset_mid_regs: got %h expected %h", regs_out, exp_vec());
      else n_pass++;
      tick();
      n_total++;
      if ({bus.write_ack, bus.read_valid} !== 2'b00) $display("FAIL reset_mid_dropped: got %b expected 00", {bus.write_ack, bus.read_valid});
      else n_pass++;
   endtask

   initial begin
      rst = 1'b1;
      hw_status = '0;
      hw_status[127:96] = 32'hCAFE;
      idle();
      tick();
      test_reset();
      test_rw_basic();
      test_strobe();
      test_w1c();
      test_errors();
      test_simultaneous();
      test_ro();
      test_wo();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
